// File: rtl/usb_defs_pkg.sv
// usb_defs_pkg: shared encodings and sizes for the USB BULK IN arbiter slice.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
// Contents: arbiter state encoding, default maximum packet length, packet-counter width,
//           and the round-robin tie-break helper.
package usb_defs_pkg;

    // State values double as the one-hot grant vector (bit0 = source 0, bit1 = source 1).
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_t;

    localparam int MAX_PACKET_LENGTH_DEF = 512;
    localparam int PKT_CNT_W             = 16;

    // Tie-break: serve whichever source did not finish the most recent packet.
    // last_src = 1 means source 1 was served last.
    function automatic arb_state_t rr_winner(input logic last_src);
        return last_src ? ST_GNT0 : ST_GNT1;
    endfunction

endpackage

// File: rtl/usb_bulk_in_arbiter_if.sv
// usb_bulk_in_arbiter_if: one 8-bit AXI-Stream byte link (tvalid/tready/tlast/tdata).
// Latency: none (wires only).
// Backpressure: tready driven by the receiving side, honoured by the sending side.
// Modports: master = byte producer (drives tvalid/tlast/tdata), slave = byte consumer (drives tready).
interface usb_bulk_in_arbiter_if;

    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic [7:0] tdata;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        output tready
    );

endinterface

// File: rtl/usb_pkt_counter.sv
// usb_pkt_counter: 16-bit wrapping event counter with enable.
// Latency: count reflects an enable pulse one clock after it is sampled.
// Backpressure: none; counts every cycle en is high, wraps 16'hFFFF -> 0.
// Ports: clock, arst_n (async active-low), en, count.
module usb_pkt_counter
    import usb_defs_pkg::*;
(
    input  logic                 clock,
    input  logic                 arst_n,
    input  logic                 en,
    output logic [PKT_CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/usb_bulk_in_arbiter.sv
// usb_bulk_in_arbiter: packet-granular 2:1 arbiter sharing the USB BULK IN byte stream.
// Latency: one-cycle grant decision from ST_IDLE, then zero-latency combinational passthrough.
// Backpressure: m.tready is steered only to the granted source; the other source sees tready = 0.
// Ports: clock / arst_n (async active-low); s0 = DDR3 read-back source, s1 = loopback/telemetry
//        source, m = BULK IN sink; grant_o one-hot grant (00 idle), split_o one-cycle pulse after a
//        length-limited packet end, pkts0_o / pkts1_o per-source completed-packet counts.
// Build option: USB_ARB_FIXED_PRIORITY_EN -- source 0 always wins ties, no round-robin state is built.
module usb_bulk_in_arbiter
    import usb_defs_pkg::*;
#(
    parameter int MAX_PACKET_LENGTH = MAX_PACKET_LENGTH_DEF,
    parameter int CBITS             = $clog2(MAX_PACKET_LENGTH + 1)
) (
    input  logic                  clock,
    input  logic                  arst_n,
    usb_bulk_in_arbiter_if.slave  s0,
    usb_bulk_in_arbiter_if.slave  s1,
    usb_bulk_in_arbiter_if.master m,
    output logic [1:0]            grant_o,
    output logic                  split_o,
    output logic [PKT_CNT_W-1:0]  pkts0_o,
    output logic [PKT_CNT_W-1:0]  pkts1_o
);

    // Byte index at which the end-point limit forces tlast.
    localparam logic [CBITS-1:0] LIMIT_IDX = CBITS'(MAX_PACKET_LENGTH - 1);

    arb_state_t       state;
    arb_state_t       tie_state;
    logic [CBITS-1:0] byte_cnt;
    logic             sel_last;
    logic             at_limit;
    logic             xfer;
    logic             pkt_end;

`ifndef USB_ARB_FIXED_PRIORITY_EN
    logic             last_src;   // 1 = source 1 finished the most recent packet
`endif

    // Winner when both sources request in the same idle cycle.
    always_comb begin
`ifdef USB_ARB_FIXED_PRIORITY_EN
        tie_state = ST_GNT0;
`else
        tie_state = rr_winner(last_src);
`endif
    end

    // Passthrough mux: the granted source is wired straight to the sink.
    always_comb begin
        m.tvalid  = 1'b0;
        m.tdata   = 8'h00;
        s0.tready = 1'b0;
        s1.tready = 1'b0;
        sel_last  = 1'b0;
        case (state)
            ST_GNT0: begin
                m.tvalid  = s0.tvalid;
                m.tdata   = s0.tdata;
                s0.tready = m.tready;
                sel_last  = s0.tlast;
            end
            ST_GNT1: begin
                m.tvalid  = s1.tvalid;
                m.tdata   = s1.tdata;
                s1.tready = m.tready;
                sel_last  = s1.tlast;
            end
            default: ;
        endcase
    end

    // tlast comes from the source or is forced on the last byte the end-point allows.
    assign at_limit = (byte_cnt == LIMIT_IDX);
    assign m.tlast  = (state != ST_IDLE) && (sel_last || at_limit);
    assign xfer     = m.tvalid && m.tready;
    assign pkt_end  = xfer && m.tlast;
    assign grant_o  = state;

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            split_o  <= 1'b0;
`ifndef USB_ARB_FIXED_PRIORITY_EN
            last_src <= 1'b1;
`endif
        end else begin
            // A forced end with the source still mid-packet is a split; the
            // remainder re-arbitrates after the idle bubble like any new packet.
            split_o <= pkt_end && !sel_last;
            case (state)
                ST_IDLE: begin
                    byte_cnt <= '0;
                    if (s0.tvalid && s1.tvalid) begin
                        state <= tie_state;
                    end else if (s0.tvalid) begin
                        state <= ST_GNT0;
                    end else if (s1.tvalid) begin
                        state <= ST_GNT1;
                    end
                end
                default: begin
                    // Grant holds through valid gaps until the tlast transfer.
                    if (xfer) begin
                        if (m.tlast) begin
                            state    <= ST_IDLE;
                            byte_cnt <= '0;
`ifndef USB_ARB_FIXED_PRIORITY_EN
                            last_src <= (state == ST_GNT1);
`endif
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    usb_pkt_counter u_pkts0 (
        .clock  (clock),
        .arst_n (arst_n),
        .en     (pkt_end && (state == ST_GNT0)),
        .count  (pkts0_o)
    );

    usb_pkt_counter u_pkts1 (
        .clock  (clock),
        .arst_n (arst_n),
        .en     (pkt_end && (state == ST_GNT1)),
        .count  (pkts1_o)
    );

    // Grant is one-hot or idle; the byte counter never passes the forced-tlast index.
    assert property (@(posedge clock) disable iff (!arst_n) $onehot0(grant_o));
    assert property (@(posedge clock) disable iff (!arst_n) byte_cnt <= LIMIT_IDX);

endmodule

// File: tb/tb_usb_bulk_in_arbiter.sv
// tb_usb_bulk_in_arbiter: directed and randomized bench for usb_bulk_in_arbiter (MAX_PACKET_LENGTH = 8).
// Latency: n/a.
// Backpressure: sink tready is held high, toggled or randomized per test.
module tb_usb_bulk_in_arbiter;

    localparam int MAXP = 8;
`ifdef USB_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clock  = 1'b0;
    logic        arst_n = 1'b1;
    logic [1:0]  grant_o;
    logic        split_o;
    logic [15:0] pkts0_o;
    logic [15:0] pkts1_o;

    usb_bulk_in_arbiter_if s0_if ();
    usb_bulk_in_arbiter_if s1_if ();
    usb_bulk_in_arbiter_if m_if ();

    usb_bulk_in_arbiter #(.MAX_PACKET_LENGTH(MAXP)) dut (
        .clock   (clock),
        .arst_n  (arst_n),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if),
        .grant_o (grant_o),
        .split_o (split_o),
        .pkts0_o (pkts0_o),
        .pkts1_o (pkts1_o)
    );

    always #5 clock = ~clock;

    int errs   = 0;
    int checks = 0;

    // Source streams: {tlast, tdata} per byte, popped on each accepted handshake.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit         xf0, xf1;
    int         rdy_mode;   // 0: ready high, 1: toggle, 2: random
    int         gap_pct;    // chance of a source withholding valid on a fresh byte

    // Reference model: who owns the sink, bytes already sent in the open output packet.
    int owner;              // -1 idle, else source index
    int open_len;
    int last_src;
    int mp0, mp1;
    bit exp_split;
    bit c_v0, c_v1, c_xfer, c_last, c_slast;

    // Observation logs.
    int         pkt_len_log[$];
    int         pkt_src_log[$];
    logic [7:0] out_bytes[$];
    logic [1:0] grant_trace[$];
    int         cur_len, split_cnt, g1_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ob(input int i);
        return (i < out_bytes.size()) ? 32'(out_bytes[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] pl(input int i);
        return (i < pkt_len_log.size()) ? 32'(pkt_len_log[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] ps(input int i);
        return (i < pkt_src_log.size()) ? 32'(pkt_src_log[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] gt(input int i);
        return (i < grant_trace.size()) ? 32'(grant_trace[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic int tie_pick();
        if (FIXED) return 0;
        return (last_src == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        owner = -1; open_len = 0; last_src = 1;
        mp0 = 0; mp1 = 0; exp_split = 1'b0; cur_len = 0;
    endtask

    task automatic clear_logs();
        pkt_len_log.delete(); pkt_src_log.delete(); out_bytes.delete(); grant_trace.delete();
        cur_len = 0; split_cnt = 0; g1_cycles = 0;
    endtask

    task automatic push_pkt(input int src, input int len, input logic [7:0] base);
        logic [8:0] w;
        for (int k = 0; k < len; k++) begin
            w[7:0] = base + 8'(k);
            w[8]   = (k == len - 1);
            if (src == 0) q0.push_back(w); else q1.push_back(w);
        end
    endtask

    // Compare every DUT output against the model, then log what moved.
    task automatic check_cycle();
        logic [1:0] eg;
        logic       ev, el, sl, er0, er1;
        logic [7:0] ed;
        eg = 2'b00; ev = 1'b0; ed = 8'h00; sl = 1'b0;
        if (owner == 0) begin
            eg = 2'b01; ev = s0_if.tvalid; ed = s0_if.tdata; sl = s0_if.tlast;
        end else if (owner == 1) begin
            eg = 2'b10; ev = s1_if.tvalid; ed = s1_if.tdata; sl = s1_if.tlast;
        end
        el  = (owner >= 0) && (sl || (open_len == MAXP - 1));
        er0 = (owner == 0) && m_if.tready;
        er1 = (owner == 1) && m_if.tready;
        chk("grant_o",   32'(grant_o),     32'(eg));
        chk("m_tvalid",  32'(m_if.tvalid), 32'(ev));
        chk("m_tdata",   32'(m_if.tdata),  32'(ed));
        chk("m_tlast",   32'(m_if.tlast),  32'(el));
        chk("s0_tready", 32'(s0_if.tready), 32'(er0));
        chk("s1_tready", 32'(s1_if.tready), 32'(er1));
        chk("split_o",   32'(split_o),     32'(exp_split));
        chk("pkts0_o",   32'(pkts0_o),     32'(mp0));
        chk("pkts1_o",   32'(pkts1_o),     32'(mp1));

        c_v0 = s0_if.tvalid; c_v1 = s1_if.tvalid;
        c_xfer = ev && m_if.tready; c_last = el; c_slast = sl;
        if (c_xfer) begin
            out_bytes.push_back(ed);
            cur_len++;
            if (el) begin
                pkt_len_log.push_back(cur_len);
                pkt_src_log.push_back(owner);
                cur_len = 0;
            end
        end
        grant_trace.push_back(grant_o);
        if (split_o) split_cnt++;
        if (grant_o == 2'b10) g1_cycles++;

        xf0 = s0_if.tvalid && s0_if.tready;
        xf1 = s1_if.tvalid && s1_if.tready;
        if (xf0 && q0.size() > 0) void'(q0.pop_front());
        if (xf1 && q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic advance();
        if (!arst_n) begin
            model_reset();
            return;
        end
        exp_split = 1'b0;
        if (owner < 0) begin
            if (c_v0 && c_v1) owner = tie_pick();
            else if (c_v0)    owner = 0;
            else if (c_v1)    owner = 1;
            open_len = 0;
        end else if (c_xfer) begin
            if (c_last) begin
                if (owner == 0) mp0 = (mp0 + 1) % 65536;
                else            mp1 = (mp1 + 1) % 65536;
                exp_split = !c_slast;
                last_src  = owner;
                owner     = -1;
                open_len  = 0;
            end else begin
                open_len++;
            end
        end
    endtask

    // Sources keep valid asserted until accepted; fresh bytes may be withheld at random.
    task automatic drive();
        logic [8:0] h;
        if (q0.size() == 0) begin
            s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0; s0_if.tdata = 8'h00;
        end else begin
            h = q0[0];
            if (!(s0_if.tvalid && !xf0)) s0_if.tvalid = ($urandom_range(99) >= gap_pct);
            s0_if.tdata = h[7:0]; s0_if.tlast = h[8];
        end
        if (q1.size() == 0) begin
            s1_if.tvalid = 1'b0; s1_if.tlast = 1'b0; s1_if.tdata = 8'h00;
        end else begin
            h = q1[0];
            if (!(s1_if.tvalid && !xf1)) s1_if.tvalid = ($urandom_range(99) >= gap_pct);
            s1_if.tdata = h[7:0]; s1_if.tlast = h[8];
        end
        case (rdy_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = ~m_if.tready;
            default: m_if.tready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic step();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        advance();
        #1;
        drive();
    endtask

    task automatic run_until(input int n, input int maxc, input string name);
        int c = 0;
        while (pkt_len_log.size() < n && c < maxc) begin
            step();
            c++;
        end
        checks++;
        if (pkt_len_log.size() < n) begin
            errs++;
            $display("FAIL %s timeout: %0d packets seen, required %0d", name, pkt_len_log.size(), n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " m_tvalid"},  32'(m_if.tvalid),  0);
        chk({tag, " m_tlast"},   32'(m_if.tlast),   0);
        chk({tag, " m_tdata"},   32'(m_if.tdata),   0);
        chk({tag, " s0_tready"}, 32'(s0_if.tready), 0);
        chk({tag, " s1_tready"}, 32'(s1_if.tready), 0);
        chk({tag, " grant_o"},   32'(grant_o),      0);
        chk({tag, " split_o"},   32'(split_o),      0);
        chk({tag, " pkts0_o"},   32'(pkts0_o),      0);
        chk({tag, " pkts1_o"},   32'(pkts1_o),      0);
    endtask

    task automatic do_reset();
        s0_if.tvalid = 1'b0; s1_if.tvalid = 1'b0;
        q0.delete(); q1.delete();
        xf0 = 1'b0; xf1 = 1'b0;
        arst_n = 1'b0;
        model_reset();
        step();
        step();
        arst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        logic [1:0] tie_exp [8];
        int c;
        int total;
        s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0; s0_if.tdata = 8'h00;
        s1_if.tvalid = 1'b0; s1_if.tlast = 1'b0; s1_if.tdata = 8'h00;
        m_if.tready  = 1'b1;
        rdy_mode = 0; gap_pct = 0;
        model_reset();
        clear_logs();
        #2;

        // Reset values.
        arst_n = 1'b0;
        #1;
        check_all_zero("reset");
        do_reset();

        // Single source: 5 bytes 10..14 from source 1.
        push_pkt(1, 5, 8'h10);
        drive();
        run_until(1, 50, "single");
        repeat (3) step();
        chk("single pkt len", pl(0), 5);
        for (int i = 0; i < 5; i++) chk("single byte", ob(i), 32'h10 + 32'(i));
        chk("single grant cycles", 32'(g1_cycles), 5);
        chk("single pkts1", 32'(pkts1_o), 1);
        chk("single splits", 32'(split_cnt), 0);

        // Tie after reset: source 0 first, one bubble, then source 1.
        do_reset();
        push_pkt(0, 3, 8'h20);
        push_pkt(1, 3, 8'h30);
        drive();
        run_until(2, 50, "tie");
        tie_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 8; i++) chk("tie grant trace", gt(i), 32'(tie_exp[i]));
        chk("tie first src", ps(0), 0);
        chk("tie second src", ps(1), 1);

        // Round-robin with 1-byte packets always pending on both sources.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            push_pkt(0, 1, 8'h40 + 8'(k));
            push_pkt(1, 1, 8'h50 + 8'(k));
        end
        drive();
        run_until(8, 100, "round-robin");
        for (int i = 0; i < 4; i++) chk("rr src order", ps(i), FIXED ? 0 : (i % 2));
        chk("rr pkts0", 32'(pkts0_o), FIXED ? 8 : 4);
        chk("rr pkts1", 32'(pkts1_o), FIXED ? 0 : 4);

        // Length split: 20 bytes through an 8-byte end-point.
        do_reset();
        push_pkt(0, 20, 8'h60);
        drive();
        run_until(3, 100, "split");
        repeat (2) step();
        chk("split len0", pl(0), 8);
        chk("split len1", pl(1), 8);
        chk("split len2", pl(2), 4);
        chk("split pulses", 32'(split_cnt), 2);
        chk("split pkts0", 32'(pkts0_o), 3);
        for (int i = 0; i < 20; i++) chk("split byte", ob(i), 32'h60 + 32'(i));

        // Backpressure: sink ready toggles every cycle, source 1 waits its turn.
        do_reset();
        rdy_mode = 1;
        push_pkt(0, 4, 8'h80);
        push_pkt(1, 2, 8'h88);
        drive();
        run_until(2, 100, "backpressure");
        chk("bp src", ps(0), 0);
        chk("bp len", pl(0), 4);
        for (int i = 0; i < 6; i++) chk("bp byte", ob(i), (i < 4) ? 32'h80 + 32'(i) : 32'h84 + 32'(i));
        rdy_mode = 0;

        // Reset mid-packet after 2 of 6 bytes.
        do_reset();
        push_pkt(0, 6, 8'h90);
        drive();
        c = 0;
        while (out_bytes.size() < 2 && c < 50) begin
            step();
            c++;
        end
        chk("midreset bytes before reset", 32'(out_bytes.size()), 2);
        #2;
        arst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        q0.delete(); q1.delete();
        s0_if.tvalid = 1'b0; xf0 = 1'b0; xf1 = 1'b0;
        step();
        step();
        arst_n = 1'b1;
        clear_logs();
        push_pkt(0, 3, 8'hA0);
        drive();
        run_until(1, 50, "after reset");
        chk("post-reset len", pl(0), 3);
        for (int i = 0; i < 3; i++) chk("post-reset byte", ob(i), 32'hA0 + 32'(i));

        // Randomized traffic: valid gaps, random ready, lengths across the split limit.
        do_reset();
        rdy_mode = 2;
        gap_pct  = 30;
        total    = 0;
        for (int p = 0; p < 60; p++) begin
            int s;
            int l;
            s = int'($urandom_range(1));
            l = int'($urandom_range(20, 1));
            push_pkt(s, l, 8'($urandom));
            total += l;
        end
        drive();
        c = 0;
        while ((q0.size() > 0 || q1.size() > 0 || owner >= 0) && c < 8000) begin
            step();
            c++;
        end
        checks++;
        if (c >= 8000) begin
            errs++;
            $display("FAIL random drain timeout: %0d/%0d bytes left", q0.size() + q1.size(), total);
        end
        repeat (3) step();
        chk("random byte total", 32'(out_bytes.size()), 32'(total));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
